uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Assembles the byte stream delivered by `uart_recv` into framed host commands (key loads, control requests) for the TemperatureCipher core. It sits directly downstream of `uart_recv`: it consumes each `uart_done` strobe with its `uart_data` byte, checks framing, length and XOR checksum, and presents a complete, validated command with a single-cycle strobe. Malformed or stalled frames are discarded and reported with an error strobe and code.

## Interface

Parameters:
- `MAX_LEN`, 8: maximum payload bytes per frame (1..16).
- `TIMEOUT_CYC`, 50000: idle `sys_clk` cycles allowed between bytes inside a frame before abort (≥2).
- `HEADER`, 8'hA5: frame start byte.

Ports:
- `sys_clk`  in  1  system clock; only clock in the block.
- `sys_rst_n`  in  1  asynchronous, active-low reset.
- `uart_done`  in  1  one-cycle strobe from `uart_recv`: `uart_data` is valid this cycle.
- `uart_data`  in  8  received byte.
- `frame_valid`  out  1  one-cycle strobe: a checked frame is on the `frame_*` outputs.
- `frame_cmd`  out  8  command byte of the last good frame.
- `frame_len`  out  8  payload length of the last good frame.
- `frame_payload`  out  8*MAX_LEN  payload; byte i at bits [8*i+7:8*i]; bytes ≥ len are zero.
- `frame_err`  out  1  one-cycle strobe: the current frame was dropped.
- `err_code`  out  2  01 = length > MAX_LEN, 10 = checksum mismatch, 11 = inter-byte timeout. Held until the next `frame_err`.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation

- Frame format: HEADER, CMD, LEN, LEN payload bytes, CHK. CHK = CMD ^ LEN ^ payload[0] ^ … ^ payload[LEN-1].
- FSM states: IDLE, CMD, LEN, DATA, CHK. Every transition is triggered only by a cycle with `uart_done`=1, except the timeout abort.
- IDLE: byte == HEADER → CMD; any other byte is ignored silently (no error).
- CMD: store byte as working cmd, seed running XOR with it → LEN.
- LEN: byte > MAX_LEN → `frame_err`, `err_code`=01, → IDLE. Byte == 0 → CHK. Otherwise → DATA. Store len, XOR it in, clear the working payload buffer and byte index.
- DATA: write byte at index, XOR it in, increment index. When index reaches len-1 on this byte → CHK.
- CHK: byte == running XOR → copy the working cmd/len/payload to the output registers and pulse `frame_valid`. Otherwise pulse `frame_err` with `err_code`=10. Either way → IDLE.
- A HEADER value appearing inside a frame is treated as ordinary data. There is no resynchronisation mid-frame.
- Timeout: the gap counter clears on every accepted byte and when in IDLE. It counts while busy. On the cycle it reaches TIMEOUT_CYC-1 with no `uart_done`, the block pulses `frame_err` with `err_code`=11 and goes → IDLE. If `uart_done` arrives in that same cycle, the byte wins and there is no timeout.
- The output `frame_*` registers change only on a good frame. They hold through errors and through subsequent frames in progress.

## Timing

- Reset (asynchronous assert, release synchronous to `sys_clk`):
  - state = IDLE.
  - All outputs are 0: `frame_valid`, `frame_err`, `busy`, `err_code`, `frame_cmd`, `frame_len`, `frame_payload`.
  - Working buffer, index, XOR and gap counter are cleared.
- Reset asserted mid-frame: the partial frame is discarded with no `frame_err`.
- Latency: `frame_valid` or `frame_err` is registered high exactly 1 cycle after the `uart_done` cycle of the deciding byte, with the data outputs updated in that same cycle.
- Both strobes last exactly 1 cycle and are never high together.
- Back-to-back `uart_done` on consecutive cycles must be accepted; there is no back-pressure.
- The block is ready for the next HEADER in the cycle following the deciding byte.
- `busy` rises the cycle after HEADER is accepted and falls together with the final strobe.

## Test plan

- Good frame A5,01,03,11,22,33,CHK=01^03^11^22^33=0x02 → one `frame_valid`. `frame_cmd`=01, `frame_len`=03, `frame_payload`[23:0]=0x332211, upper bits 0. `frame_err` stays 0.
- Zero-length frame A5,7E,00,7E → `frame_valid`, `frame_len`=0, `frame_payload`=0. Then the garbage bytes 00,FF,A4 → no strobe, `busy`=0.
- Bad checksum A5,01,01,55,55 (expected 55) → wait, correct XOR = 01^01^55=55. So send 56 instead → `frame_err`, `err_code`=10. Previous `frame_*` outputs are unchanged.
- LEN=09 with MAX_LEN=8: A5,02,09 → `frame_err`, `err_code`=01 one cycle after the LEN byte. A following good frame is decoded correctly.
- Timeout with TIMEOUT_CYC=10: A5,01, then silence → `frame_err`, `err_code`=11 when the 10th idle cycle completes. Separately, a byte arriving exactly at cycle 9 → no timeout, and the frame completes.
- Reset pulse after A5,01,02,AA → all outputs 0, no strobe. A full good frame after reset release decodes normally, driven with back-to-back `uart_done` cycles.

Source files
------------

// File: rtl/uart_frame_parser.sv
// Frame assembler behind uart_recv: HEADER, CMD, LEN, payload, XOR check byte.
// Emits one-cycle frame_valid / frame_err strobes; good frames update frame_* outputs.
module uart_frame_parser #(
    parameter int         MAX_LEN     = 8,
    parameter int         TIMEOUT_CYC = 50000,
    parameter logic [7:0] HEADER      = 8'hA5
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 uart_done,
    input  logic [7:0]           uart_data,
    output logic                 frame_valid,
    output logic [7:0]           frame_cmd,
    output logic [7:0]           frame_len,
    output logic [8*MAX_LEN-1:0] frame_payload,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    localparam int            PW       = 8 * MAX_LEN;
    localparam int            GW       = $clog2(TIMEOUT_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    xor_q, xor_d;
    logic [PW-1:0] buf_q, buf_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic [7:0]    ocmd_q, ocmd_d;
    logic [7:0]    olen_q, olen_d;
    logic [PW-1:0] opay_q, opay_d;

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        xor_d   = xor_q;
        buf_d   = buf_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        ocmd_d  = ocmd_q;
        olen_d  = olen_q;
        opay_d  = opay_q;
        gap_d   = (state_q == S_IDLE || uart_done) ? '0 : gap_q + GW'(1);

        if (uart_done) begin
            unique case (state_q)
                S_IDLE: begin
                    if (uart_data == HEADER) state_d = S_CMD;
                end
                S_CMD: begin
                    cmd_d   = uart_data;
                    xor_d   = uart_data;
                    state_d = S_LEN;
                end
                S_LEN: begin
                    if (uart_data > LEN_MAX) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = S_IDLE;
                    end else begin
                        len_d   = uart_data;
                        xor_d   = xor_q ^ uart_data;
                        buf_d   = '0;
                        idx_d   = '0;
                        state_d = (uart_data == 8'd0) ? S_CHK : S_DATA;
                    end
                end
                S_DATA: begin
                    for (int i = 0; i < MAX_LEN; i++) begin
                        if (idx_q == 8'(i)) buf_d[8*i +: 8] = uart_data;
                    end
                    xor_d = xor_q ^ uart_data;
                    idx_d = idx_q + 8'd1;
                    if (idx_q == len_q - 8'd1) state_d = S_CHK;
                end
                S_CHK: begin
                    if (uart_data == xor_q) begin
                        valid_d = 1'b1;
                        ocmd_d  = cmd_q;
                        olen_d  = len_q;
                        opay_d  = buf_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b10;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE && gap_q == GAP_LAST) begin
            // a byte landing on the last allowed cycle takes priority over the abort
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            xor_q   <= '0;
            buf_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            ocmd_q  <= '0;
            olen_q  <= '0;
            opay_q  <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            xor_q   <= xor_d;
            buf_q   <= buf_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            ocmd_q  <= ocmd_d;
            olen_q  <= olen_d;
            opay_q  <= opay_d;
        end
    end

    assign frame_valid   = valid_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;
    assign frame_cmd     = ocmd_q;
    assign frame_len     = olen_q;
    assign frame_payload = opay_q;
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed table, corner sequences,
// and random frames scored against a frame-level reference model.
module tb_uart_frame_parser;

    localparam int ML = 8;
    localparam int TO = 10;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          uart_done = 1'b0;
    logic [7:0]    uart_data = 8'h00;
    logic          frame_valid;
    logic [7:0]    frame_cmd;
    logic [7:0]    frame_len;
    logic [8*ML-1:0] frame_payload;
    logic          frame_err;
    logic [1:0]    err_code;
    logic          busy;

    uart_frame_parser #(
        .MAX_LEN    (ML),
        .TIMEOUT_CYC(TO),
        .HEADER     (8'hA5)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_done    (uart_done),
        .uart_data    (uart_data),
        .frame_valid  (frame_valid),
        .frame_cmd    (frame_cmd),
        .frame_len    (frame_len),
        .frame_payload(frame_payload),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  fb[$];
    logic [7:0]  e_cmd, e_len;
    logic [63:0] e_pay;
    logic [1:0]  e_code;
    logic        s_valid, s_err;
    logic        last_v, last_e;

    typedef struct {
        int          n;
        logic [7:0]  b[12];
        logic        good;
        logic [1:0]  code;
        logic [7:0]  cmd;
        logic [7:0]  len;
        logic [63:0] pay;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic d, input logic [7:0] b);
        uart_done = d;
        uart_data = b;
        @(posedge sys_clk);
        #1;
        uart_done = 1'b0;
        s_valid = frame_valid;
        s_err   = frame_err;
    endtask

    // Reference: decide the frame outcome from the byte list alone.
    task automatic model(output int d, output logic good, output logic [1:0] code,
                         output logic [7:0] cmd, output logic [7:0] len,
                         output logic [63:0] pay);
        logic [7:0] x;
        cmd  = fb[1];
        len  = fb[2];
        pay  = '0;
        code = 2'b00;
        good = 1'b0;
        if (int'(len) > ML) begin
            d    = 2;
            code = 2'b01;
        end else begin
            x = cmd ^ len;
            for (int i = 0; i < int'(len); i++) begin
                pay[8*i +: 8] = fb[3+i];
                x = x ^ fb[3+i];
            end
            d = 3 + int'(len);
            if (fb[d] == x) good = 1'b1;
            else code = 2'b10;
        end
    endtask

    task automatic run_frame(input int gapmax);
        int          d;
        logic        good;
        logic [1:0]  code;
        logic [7:0]  cmd, len;
        logic [63:0] pay;
        int          bad_s = 0;
        int          bad_b = 0;
        model(d, good, code, cmd, len, pay);
        for (int i = 0; i < fb.size(); i++) begin
            if (i > 0) begin
                repeat ($urandom_range(gapmax, 0)) begin
                    cyc(1'b0, 8'h00);
                    if (s_valid || s_err) bad_s++;
                    if (busy !== 1'b1) bad_b++;
                end
            end
            cyc(1'b1, fb[i]);
            if (i == d) begin
                last_v = s_valid;
                last_e = s_err;
                if (s_valid !== good || s_err !== !good) bad_s++;
                if (busy !== 1'b0) bad_b++;
            end else begin
                if (s_valid || s_err) bad_s++;
                if (busy !== 1'b1) bad_b++;
            end
        end
        if (good) begin
            e_cmd = cmd;
            e_len = len;
            e_pay = pay;
        end else begin
            e_code = code;
        end
        check("frame_strobes", 96'(bad_s), 96'd0);
        check("frame_busy", 96'(bad_b), 96'd0);
        check("frame_errcode", 96'(err_code), 96'(e_code));
        check("frame_outputs", 96'({frame_cmd, frame_len, frame_payload}),
              96'({e_cmd, e_len, e_pay}));
    endtask

    task automatic gen_frame();
        logic [7:0] cmd, len, x, b;
        fb.delete();
        cmd = 8'($urandom);
        len = 8'($urandom_range(10, 0));
        fb.push_back(8'hA5);
        fb.push_back(cmd);
        fb.push_back(len);
        if (int'(len) > ML) return;
        x = cmd ^ len;
        for (int i = 0; i < int'(len); i++) begin
            b = ($urandom_range(4, 0) == 0) ? 8'hA5 : 8'($urandom);
            fb.push_back(b);
            x = x ^ b;
        end
        if ($urandom_range(3, 0) == 0) x = x ^ (8'h01 << $urandom_range(7, 0));
        fb.push_back(x);
    endtask

    task automatic load(input logic [7:0] b[$]);
        fb = b;
    endtask

    initial begin
        int bad;
        logic [7:0] g;

        tbl[0] = '{7, '{8'hA5,8'h01,8'h03,8'h11,8'h22,8'h33,8'h02,0,0,0,0,0},
                   1'b1, 2'b00, 8'h01, 8'h03, 64'h0000_0000_0033_2211};
        tbl[1] = '{4, '{8'hA5,8'h7E,8'h00,8'h7E,0,0,0,0,0,0,0,0},
                   1'b1, 2'b00, 8'h7E, 8'h00, 64'h0};
        tbl[2] = '{5, '{8'hA5,8'h01,8'h01,8'h55,8'h56,0,0,0,0,0,0,0},
                   1'b0, 2'b10, 8'h7E, 8'h00, 64'h0};
        tbl[3] = '{3, '{8'hA5,8'h02,8'h09,0,0,0,0,0,0,0,0,0},
                   1'b0, 2'b01, 8'h7E, 8'h00, 64'h0};
        tbl[4] = '{6, '{8'hA5,8'h10,8'h02,8'hA5,8'h5A,8'hED,0,0,0,0,0,0},
                   1'b1, 2'b01, 8'h10, 8'h02, 64'h5AA5};
        tbl[5] = '{12, '{8'hA5,8'h03,8'h08,8'h01,8'h02,8'h03,8'h04,
                         8'h05,8'h06,8'h07,8'h08,8'h03},
                   1'b1, 2'b01, 8'h03, 8'h08, 64'h0807_0605_0403_0201};

        sys_rst_n = 1'b1;
        #2 sys_rst_n = 1'b0;
        #20;
        check("reset_outputs",
              96'({frame_valid, frame_err, busy, err_code, frame_cmd, frame_len, frame_payload}),
              96'd0);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        e_cmd = 0; e_len = 0; e_pay = 0; e_code = 0;

        for (int v = 0; v < 6; v++) begin
            fb.delete();
            for (int i = 0; i < tbl[v].n; i++) fb.push_back(tbl[v].b[i]);
            run_frame(v % 3);
            check($sformatf("tbl%0d_strobe", v), 96'({last_v, last_e}),
                  96'({tbl[v].good, !tbl[v].good}));
            check($sformatf("tbl%0d_code", v), 96'(err_code), 96'(tbl[v].code));
            check($sformatf("tbl%0d_out", v),
                  96'({frame_cmd, frame_len, frame_payload}),
                  96'({tbl[v].cmd, tbl[v].len, tbl[v].pay}));
            if (v == 1) begin
                bad = 0;
                foreach (tbl[1].b[k]) if (k < 3) begin
                    g = (k == 0) ? 8'h00 : (k == 1) ? 8'hFF : 8'hA4;
                    cyc(1'b1, g);
                    if (s_valid || s_err || busy) bad++;
                end
                check("garbage_idle", 96'(bad), 96'd0);
            end
        end

        // Timeout: ten silent cycles after the CMD byte
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h01);
        bad = 0;
        for (int k = 1; k <= TO; k++) begin
            cyc(1'b0, 8'h00);
            if (k < TO && (s_valid || s_err)) bad++;
        end
        check("timeout_strobe", 96'({s_valid, s_err}), 96'(2'b01));
        check("timeout_early", 96'(bad), 96'd0);
        check("timeout_code", 96'(err_code), 96'(2'b11));
        check("timeout_busy", 96'(busy), 96'd0);
        e_code = 2'b11;

        // Byte on the last allowed cycle beats the timeout
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h01);
        bad = 0;
        repeat (TO - 1) begin
            cyc(1'b0, 8'h00);
            if (s_valid || s_err) bad++;
        end
        cyc(1'b1, 8'h00);
        if (s_valid || s_err || !busy) bad++;
        cyc(1'b1, 8'h01);
        check("edge_no_timeout", 96'(bad), 96'd0);
        check("edge_valid", 96'({s_valid, s_err}), 96'(2'b10));
        e_cmd = 8'h01; e_len = 8'h00; e_pay = 64'h0;
        check("edge_outputs", 96'({frame_cmd, frame_len, frame_payload}),
              96'({e_cmd, e_len, e_pay}));

        // Reset in the middle of a frame
        cyc(1'b1, 8'hA5);
        cyc(1'b1, 8'h01);
        cyc(1'b1, 8'h02);
        cyc(1'b1, 8'hAA);
        #2 sys_rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              96'({frame_valid, frame_err, busy, err_code, frame_cmd, frame_len, frame_payload}),
              96'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk) sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("postreset_quiet", 96'({frame_valid, frame_err, busy}), 96'd0);
        e_cmd = 0; e_len = 0; e_pay = 0; e_code = 0;
        load('{8'hA5, 8'h21, 8'h02, 8'hC3, 8'h3C, 8'hDC});
        run_frame(0);
        check("postreset_good", 96'({last_v, frame_cmd, frame_len, frame_payload}),
              96'({1'b1, 8'h21, 8'h02, 64'h3CC3}));

        // Random frames with idle-state noise and random gaps
        bad = 0;
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(2, 0)) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                cyc(1'b1, g);
                if (s_valid || s_err || busy) bad++;
            end
            gen_frame();
            run_frame(TO - 1);
        end
        check("random_noise", 96'(bad), 96'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
